// File: rtl/traffic_signal_multi.sv
// Highway / multi side-road traffic controller: latched side requests served round-robin,
// Moore FSM with registered lamps. Optional emergency preemption via `TRAFFIC_PREEMPT_EN.
module traffic_signal_multi #(
  parameter int unsigned NUM_SIDE       = 2,
  parameter int unsigned CNT_W          = 8,
  parameter int unsigned HWY_MIN_GREEN  = 16,
  parameter int unsigned SIDE_MIN_GREEN = 4,
  parameter int unsigned SIDE_MAX_GREEN = 12,
  parameter int unsigned YELLOW_T       = 3,
  parameter int unsigned ALL_RED_T      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_SIDE-1:0]   sensor,
`ifdef TRAFFIC_PREEMPT_EN
  input  logic                  preempt,
`endif
  output logic [1:0]            highway_signal,
  output logic [2*NUM_SIDE-1:0] side_signal,
  output logic [2:0]            active_side
);

  localparam logic [1:0] LAMP_RED = 2'b00;
  localparam logic [1:0] LAMP_YEL = 2'b01;
  localparam logic [1:0] LAMP_GRN = 2'b10;

  localparam logic [CNT_W-1:0] AR_LAST   = CNT_W'(ALL_RED_T - 1);
  localparam logic [CNT_W-1:0] HWY_LAST  = CNT_W'(HWY_MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] SMIN_LAST = CNT_W'(SIDE_MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] SMAX_LAST = CNT_W'(SIDE_MAX_GREEN - 1);

  typedef enum logic [2:0] {
    ST_AR_TO_HWY,
    ST_HWY_GREEN,
    ST_HWY_YELLOW,
    ST_AR_TO_SIDE,
    ST_SIDE_GREEN,
    ST_SIDE_YELLOW
  } state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [NUM_SIDE-1:0]   r_pend;
  logic [2:0]            r_active_side;
  logic [1:0]            r_hwy_lamp;
  logic [2*NUM_SIDE-1:0] r_side_lamp;

  state_t                w_state_nxt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [NUM_SIDE-1:0]   w_pend_nxt;
  logic [2:0]            w_active_nxt;
  logic [1:0]            w_hwy_nxt;
  logic [2*NUM_SIDE-1:0] w_side_nxt;
  logic                  w_preempt;
  logic                  w_sensor_g;
  logic                  w_grant_vld;
  logic [2:0]            w_grant_idx;
  logic                  w_grant_edge;
  int unsigned           w_start;

`ifdef TRAFFIC_PREEMPT_EN
  assign w_preempt = preempt;
`else
  assign w_preempt = 1'b0;
`endif

  assign w_start = 32'(r_active_side);

  // Round-robin search: first pending side after the last one served.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    for (int unsigned k = 1; k <= NUM_SIDE; k++) begin
      for (int unsigned i = 0; i < NUM_SIDE; i++) begin
        if (!w_grant_vld && r_pend[i] && (((w_start + k) % NUM_SIDE) == i)) begin
          w_grant_vld = 1'b1;
          w_grant_idx = 3'(i);
        end
      end
    end
  end

  // Sensor of the currently granted side.
  always_comb begin
    w_sensor_g = 1'b0;
    for (int unsigned i = 0; i < NUM_SIDE; i++) begin
      if (r_active_side == 3'(i)) w_sensor_g = sensor[i];
    end
  end

  // Next state, counter, grant and lamp values for the coming edge.
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_edge = 1'b0;
    w_active_nxt = r_active_side;
    w_cnt_nxt    = r_cnt + CNT_W'(1);
    w_hwy_nxt    = LAMP_RED;
    w_side_nxt   = '0;

    case (r_state)
      ST_AR_TO_HWY: begin
        if (r_cnt == AR_LAST) w_state_nxt = ST_HWY_GREEN;
      end
      ST_HWY_GREEN: begin
        if ((r_cnt == HWY_LAST) && (|r_pend) && !w_preempt) w_state_nxt = ST_HWY_YELLOW;
      end
      ST_HWY_YELLOW: begin
        if (r_cnt == YEL_LAST) w_state_nxt = ST_AR_TO_SIDE;
      end
      ST_AR_TO_SIDE: begin
        if (w_preempt) begin
          w_state_nxt = ST_AR_TO_HWY;
        end else if (r_cnt == AR_LAST) begin
          w_state_nxt = w_grant_vld ? ST_SIDE_GREEN : ST_AR_TO_HWY;
        end
      end
      ST_SIDE_GREEN: begin
        if (w_preempt || (r_cnt == SMAX_LAST) || ((r_cnt >= SMIN_LAST) && !w_sensor_g))
          w_state_nxt = ST_SIDE_YELLOW;
      end
      ST_SIDE_YELLOW: begin
        if (r_cnt == YEL_LAST) w_state_nxt = ST_AR_TO_HWY;
      end
      default: w_state_nxt = ST_AR_TO_HWY;
    endcase

    w_grant_edge = (r_state == ST_AR_TO_SIDE) && (w_state_nxt == ST_SIDE_GREEN);
    if (w_grant_edge) w_active_nxt = w_grant_idx;

    // Highway green counter saturates so a late request exits right away.
    if (w_state_nxt != r_state) begin
      w_cnt_nxt = '0;
    end else if ((r_state == ST_HWY_GREEN) && (r_cnt == HWY_LAST)) begin
      w_cnt_nxt = r_cnt;
    end

    case (w_state_nxt)
      ST_HWY_GREEN:  w_hwy_nxt = LAMP_GRN;
      ST_HWY_YELLOW: w_hwy_nxt = LAMP_YEL;
      default:       w_hwy_nxt = LAMP_RED;
    endcase

    for (int unsigned i = 0; i < NUM_SIDE; i++) begin
      if (w_active_nxt == 3'(i)) begin
        if (w_state_nxt == ST_SIDE_GREEN)  w_side_nxt[2*i +: 2] = LAMP_GRN;
        if (w_state_nxt == ST_SIDE_YELLOW) w_side_nxt[2*i +: 2] = LAMP_YEL;
      end
    end
  end

  // Request latches: a side cannot re-request while it is green; grant clear wins.
  always_comb begin
    w_pend_nxt = r_pend;
    for (int unsigned i = 0; i < NUM_SIDE; i++) begin
      if (sensor[i] && !((r_state == ST_SIDE_GREEN) && (r_active_side == 3'(i))))
        w_pend_nxt[i] = 1'b1;
      if (w_grant_edge && (w_grant_idx == 3'(i)))
        w_pend_nxt[i] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_AR_TO_HWY;
      r_cnt         <= '0;
      r_pend        <= '0;
      r_active_side <= 3'(NUM_SIDE - 1);
      r_hwy_lamp    <= LAMP_RED;
      r_side_lamp   <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_pend        <= w_pend_nxt;
      r_active_side <= w_active_nxt;
      r_hwy_lamp    <= w_hwy_nxt;
      r_side_lamp   <= w_side_nxt;
    end
  end

  assign highway_signal = r_hwy_lamp;
  assign side_signal    = r_side_lamp;
  assign active_side    = r_active_side;

endmodule

// File: tb/tb_traffic_signal_multi.sv
// Directed bench for traffic_signal_multi (default parameters, two side roads).
// Phase lengths are measured as runs of identical lamp patterns sampled on negedges.
module tb_traffic_signal_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] sensor;
`ifdef TRAFFIC_PREEMPT_EN
  logic       preempt;
`endif
  logic [1:0] highway_signal;
  logic [3:0] side_signal;
  logic [2:0] active_side;

  int   checks   = 0;
  int   failures = 0;
  logic mon_en   = 1'b0;
  int   nonred;
  logic bad_code;

  // Lamp pattern {highway, side1, side0}.
  localparam logic [5:0] V_RED = 6'b00_00_00;
  localparam logic [5:0] V_HG  = 6'b10_00_00;
  localparam logic [5:0] V_HY  = 6'b01_00_00;
  localparam logic [5:0] V_S0G = 6'b00_00_10;
  localparam logic [5:0] V_S0Y = 6'b00_00_01;
  localparam logic [5:0] V_S1G = 6'b00_10_00;
  localparam logic [5:0] V_S1Y = 6'b00_01_00;

  logic [5:0] lamps;
  assign lamps = {highway_signal, side_signal};

  traffic_signal_multi dut (
    .clk            (clk),
    .rst            (rst),
    .sensor         (sensor),
`ifdef TRAFFIC_PREEMPT_EN
    .preempt        (preempt),
`endif
    .highway_signal (highway_signal),
    .side_signal    (side_signal),
    .active_side    (active_side)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Count consecutive negedges showing pattern val (capped at 64).
  task automatic run(input logic [5:0] val, input int exp, input string tag);
    int n;
    n = 0;
    while ((lamps === val) && (n < 64)) begin
      n++;
      @(negedge clk);
    end
    check(tag, 32'(n), 32'(exp));
  endtask

  // Safety: no illegal code, at most one non-red lamp group.
  always @(negedge clk) begin
    if (mon_en && (rst === 1'b0)) begin
      nonred   = 0;
      bad_code = (highway_signal === 2'b11);
      if (highway_signal !== 2'b00) nonred++;
      for (int i = 0; i < 2; i++) begin
        if (side_signal[2*i +: 2] !== 2'b00) nonred++;
        if (side_signal[2*i +: 2] === 2'b11) bad_code = 1'b1;
      end
      check("safety", 32'((nonred <= 1) && !bad_code), 32'd1);
    end
  end

  initial begin
    rst    = 1'b1;
    sensor = 2'b00;
`ifdef TRAFFIC_PREEMPT_EN
    preempt = 1'b0;
`endif
    // Reset and first highway green.
    repeat (10) @(negedge clk);
    check("t1_reset_hwy", 32'(highway_signal), 32'd0);
    check("t1_reset_side", 32'(side_signal), 32'd0);
    check("t1_reset_active", 32'(active_side), 32'd1);
    rst    = 1'b0;
    mon_en = 1'b1;
    run(V_RED, 2, "t1_allred");
    check("t1_hwy_green", 32'(highway_signal), 32'h2);

    // One-cycle request on side 0, five cycles into highway green.
    repeat (5) @(negedge clk);
    sensor = 2'b01;
    @(negedge clk);
    sensor = 2'b00;
    run(V_HG, 10, "t2_hwy_green_rest");
    run(V_HY, 3, "t2_hwy_yellow");
    run(V_RED, 2, "t2_allred_side");
    check("t2_active0", 32'(active_side), 32'd0);
    run(V_S0G, 4, "t2_side0_min_green");
    run(V_S0Y, 3, "t2_side0_yellow");
    run(V_RED, 2, "t2_allred_hwy");
    check("t2_hwy_back", 32'(highway_signal), 32'h2);

    // Side 1 held: max green, then re-latched request served again.
    sensor = 2'b10;
    run(V_HG, 16, "t3_hwy_green");
    run(V_HY, 3, "t3_hwy_yellow");
    run(V_RED, 2, "t3_allred_a");
    check("t3_active1", 32'(active_side), 32'd1);
    run(V_S1G, 12, "t3_side1_max_green");
    run(V_S1Y, 3, "t3_side1_yellow");
    sensor = 2'b00;
    run(V_RED, 2, "t3_allred_b");
    run(V_HG, 16, "t3_hwy_green2");
    run(V_HY, 3, "t3_hwy_yellow2");
    run(V_RED, 2, "t3_allred_c");
    check("t3_active1_again", 32'(active_side), 32'd1);
    run(V_S1G, 4, "t3_side1_second");
    run(V_S1Y, 3, "t3_side1_yellow2");
    run(V_RED, 2, "t3_allred_d");

    // Both sides request with active_side=1: side 0 first, then side 1.
    check("t4_active_start", 32'(active_side), 32'd1);
    sensor = 2'b11;
    @(negedge clk);
    sensor = 2'b00;
    run(V_HG, 15, "t4_hwy_green");
    run(V_HY, 3, "t4_hwy_yellow");
    run(V_RED, 2, "t4_allred_a");
    check("t4_first_side0", 32'(active_side), 32'd0);
    run(V_S0G, 4, "t4_side0_green");
    run(V_S0Y, 3, "t4_side0_yellow");
    run(V_RED, 2, "t4_allred_b");
    run(V_HG, 16, "t4_hwy_between");
    run(V_HY, 3, "t4_hwy_yellow2");
    run(V_RED, 2, "t4_allred_c");
    check("t4_then_side1", 32'(active_side), 32'd1);

    // Reset during side 1 green with side 0 pending.
    sensor = 2'b01;
    @(negedge clk);
    check("t5_side1_green", 32'(lamps), 32'(V_S1G));
    rst    = 1'b1;
    sensor = 2'b00;
    @(negedge clk);
    check("t5_reset_lamps", 32'(lamps), 32'd0);
    check("t5_reset_active", 32'(active_side), 32'd1);
    rst = 1'b0;
    run(V_RED, 2, "t5_allred");
    run(V_HG, 64, "t5_hwy_hold_pend_cleared");

`ifdef TRAFFIC_PREEMPT_EN
    // Preemption: highway holds, then side green cut short.
    preempt = 1'b1;
    sensor  = 2'b01;
    @(negedge clk);
    sensor = 2'b00;
    run(V_HG, 64, "t6_hwy_hold_preempt");
    preempt = 1'b0;
    run(V_HG, 1, "t6_hwy_release");
    run(V_HY, 3, "t6_hwy_yellow");
    run(V_RED, 2, "t6_allred_a");
    check("t6_active0", 32'(active_side), 32'd0);
    sensor = 2'b01;
    @(negedge clk);
    check("t6_side0_cycle1", 32'(lamps), 32'(V_S0G));
    preempt = 1'b1;
    @(negedge clk);
    run(V_S0Y, 3, "t6_side0_yellow");
    run(V_RED, 2, "t6_allred_b");
    run(V_HG, 64, "t6_hwy_hold_with_pend");
    preempt = 1'b0;
    sensor  = 2'b00;
    run(V_HG, 1, "t6_hwy_exit_pend");
`endif

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
